serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/serial_adder_ctrl_fa.sv | 21 ++
 rtl/serial_adder_ctrl.sv | 100 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the default operand width.
package serial_adder_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// One-bit gate-level full-adder cell.
// Ports: a, b, ci - addend bits and carry-in; s - sum bit; co - carry-out.
module serial_adder_ctrl_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic ab_x;
    logic ab_a;
    logic cx_a;

    xor g_x0 (ab_x, a, b);
    xor g_x1 (s, ab_x, ci);
    and g_a0 (ab_a, a, b);
    and g_a1 (cx_a, ab_x, ci);
    or  g_o0 (co, ab_a, cx_a);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: computes {cout,sum} = a + b + cin one bit
// per clock, LSB first, through a single full-adder cell.
// Ports: clk, rst (sync, active-high); start, a, b, cin - request and
// operands captured on the accepting edge; busy - high in RUN; done -
// one-cycle result-valid pulse; sum, cout, overflow - registered results.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic               fa_s;
    logic               fa_co;
    logic               accept;
    logic               last;

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (idx == IDX_W'(WIDTH - 1));

    serial_adder_ctrl_fa u_fa (
        .a  (a_q[idx]),
        .b  (b_q[idx]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // State register; busy/done are flopped decodes of the state entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state == RUN);
            done  <= (next_state == DONE);
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last)  next_state = DONE;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand capture and serial datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            idx   <= '0;
        end else if (state == RUN) begin
            sum[idx] <= fa_s;
            carry    <= fa_co;
            if (last) begin
                // carry still holds the carry into the MSB here
                cout     <= fa_co;
                overflow <= carry ^ fa_co;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        logic [31:0]  acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int unsigned  n_pass  = 0;
    int unsigned  n_total = 0;
    logic [31:0]  cyc = 0;
    exp_t         sb[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: plain integer arithmetic, signed range test for overflow.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                                   input logic [31:0] acc);
        exp_t e;
        int unsigned u;
        int sgn;
        u = int'(ta) + int'(tb_) + int'(tc);
        sgn = int'($signed(ta)) + int'($signed(tb_)) + int'(tc);
        e.s   = W'(u);
        e.co  = (u >= (1 << W));
        e.ov  = (sgn > (1 << (W - 1)) - 1) || (sgn < -(1 << (W - 1)));
        e.acc = acc;
        return e;
    endfunction

    // Issue one operation from IDLE/DONE; returns at the negedge of its DONE cycle.
    // glitch=1 pulses start with other operands at RUN cycles 3 and 5.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input bit glitch);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(negedge clk);
        sb.push_back(model(ta, tb_, tc, cyc));
        for (int i = 0; i < int'(W); i++) begin
            start = glitch && (i == 2 || i == 4);
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // Monitor: pop and compare on every done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && done) chk("busy_and_done", 32'(busy && done), 32'd0);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sum",      32'(sum),      32'(e.s));
                    chk("cout",     32'(cout),     32'(e.co));
                    chk("overflow", 32'(overflow), 32'(e.ov));
                    chk("latency",  cyc,           e.acc + W);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d results outstanding", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c0;
        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(sum),  32'd0);
        chk("rst_cout_ovf", 32'({cout, overflow}), 32'd0);
        @(negedge clk);

        // Directed boundary cases
        run_op(8'h7F, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        run_op(8'h80, 8'h80, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("hold_sum_idle", 32'(sum), 32'h00);
        chk("hold_flags_idle", 32'({cout, overflow}), 32'b11);

        // start pulses during RUN are ignored
        run_op(8'h33, 8'h44, 1'b0, 1'b1);
        repeat (3) @(negedge clk);

        // start held high: back-to-back results every W+1 cycles
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        c0 = cyc;
        for (int k = 0; k < 3; k++) sb.push_back(model(8'h12, 8'h34, 1'b0, c0 + 32'(k * (W + 1))));
        while (cyc != c0 + 2 * (W + 1)) @(negedge clk);
        start = 1'b0;
        repeat (W + 2) @(negedge clk);

        // reset during RUN cycle 4 aborts with no done
        a = 8'h55; b = 8'h66; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_outs", 32'({sum, cout, overflow}), 32'd0);
        repeat (W + 2) @(negedge clk);
        run_op(8'h0A, 8'h05, 1'b0, 1'b0);

        // Random sweep, mixing back-to-back and gapped operations
        for (int n = 0; n < 3000; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int t = 0; t < 3 * int'(W) && sb.size() != 0; t++) @(negedge clk);
        chk("outstanding_results", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
